// File: rtl/rk_stage_bank.sv
// ============================================================================
// Module      : rk_stage_bank
// Description : Bank of SLOTS load-enabled WIDTH-bit registers holding RK stage
//               results, with addressed writes, two registered read ports,
//               per-slot valid tracking, completion pulse and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rk_stage_bank #(
    parameter int WIDTH  = 32,
    parameter int SLOTS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SCLR,
    input  logic              LD,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  DATA_IN,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [WIDTH-1:0]  DATA_A,
    output logic [WIDTH-1:0]  DATA_B,
    output logic [SLOTS-1:0]  VALID,
    output logic              ALL_VALID,
    output logic              DONE,
    output logic              OVW_ERR,
    output logic              ADDR_ERR
);

    logic [WIDTH-1:0] slot_q [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] valid_d;
    logic [WIDTH-1:0] data_a_q;
    logic [WIDTH-1:0] data_a_d;
    logic [WIDTH-1:0] data_b_q;
    logic [WIDTH-1:0] data_b_d;
    logic             done_q;
    logic             done_d;
    logic             ovw_q;
    logic             ovw_d;
    logic             aerr_q;
    logic             aerr_d;

    logic [SLOTS-1:0] w_wr_sel;
    logic             w_wr_ok;
    logic             w_rda_ok;
    logic             w_rdb_ok;

    // Range checks only exist when the address space is larger than the bank.
    generate
        if ((1 << ADDR_W) > SLOTS) begin : g_addr_chk
            localparam logic [ADDR_W-1:0] c_SLOTS = ADDR_W'(SLOTS);
            assign w_wr_ok  = (WR_ADDR   < c_SLOTS);
            assign w_rda_ok = (RD_ADDR_A < c_SLOTS);
            assign w_rdb_ok = (RD_ADDR_B < c_SLOTS);
        end else begin : g_addr_full
            assign w_wr_ok  = 1'b1;
            assign w_rda_ok = 1'b1;
            assign w_rdb_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_wr_sel[i] = LD && (WR_ADDR == ADDR_W'(i));
        end
    end

    // Out-of-range read addresses match no slot and therefore read as zero.
    always_comb begin
        data_a_d = '0;
        data_b_d = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (RD_ADDR_A == ADDR_W'(i)) begin
                data_a_d = w_wr_sel[i] ? DATA_IN : slot_q[i];
            end
            if (RD_ADDR_B == ADDR_W'(i)) begin
                data_b_d = w_wr_sel[i] ? DATA_IN : slot_q[i];
            end
        end
        if (SCLR) begin
            data_a_d = '0;
            data_b_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q | w_wr_sel;
        ovw_d   = ovw_q | (|(valid_q & w_wr_sel));
        aerr_d  = aerr_q | (LD & ~w_wr_ok) | ~w_rda_ok | ~w_rdb_ok;
        if (SCLR) begin
            valid_d = '0;
            ovw_d   = 1'b0;
            aerr_d  = 1'b0;
        end
        done_d = (&valid_d) & ~(&valid_q);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (SCLR) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (w_wr_sel[i]) begin
                    slot_q[i] <= DATA_IN;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            valid_q  <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            done_q   <= 1'b0;
            ovw_q    <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            done_q   <= done_d;
            ovw_q    <= ovw_d;
            aerr_q   <= aerr_d;
        end
    end

    assign DATA_A    = data_a_q;
    assign DATA_B    = data_b_q;
    assign VALID     = valid_q;
    assign ALL_VALID = &valid_q;
    assign DONE      = done_q;
    assign OVW_ERR   = ovw_q;
    assign ADDR_ERR  = aerr_q;

endmodule

`default_nettype wire

// File: tb/tb_rk_stage_bank.sv
// ============================================================================
// Module      : tb_rk_stage_bank
// Description : Self-checking bench for rk_stage_bank (SLOTS=4 and SLOTS=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rk_stage_bank;

    logic        CLK;
    logic        CLR;
    logic        SCLR;
    logic        LD;
    logic [1:0]  WA;
    logic [31:0] DIN;
    logic [1:0]  RA;
    logic [1:0]  RB;

    logic [31:0] da4, db4, da3, db3;
    logic [3:0]  v4;
    logic [2:0]  v3;
    logic        av4, dn4, ovw4, ae4;
    logic        av3, dn3, ovw3, ae3;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Reference state, index 0 = 4-slot bank, index 1 = 3-slot bank
    logic [31:0] m_slot [2][4];
    logic [3:0]  m_valid [2];
    logic [31:0] m_da [2];
    logic [31:0] m_db [2];
    logic        m_done [2];
    logic        m_ovw [2];
    logic        m_aerr [2];

    rk_stage_bank #(.WIDTH(32), .SLOTS(4), .ADDR_W(2)) u_dut4 (
        .CLK(CLK), .CLR(CLR), .SCLR(SCLR), .LD(LD), .WR_ADDR(WA), .DATA_IN(DIN),
        .RD_ADDR_A(RA), .RD_ADDR_B(RB), .DATA_A(da4), .DATA_B(db4), .VALID(v4),
        .ALL_VALID(av4), .DONE(dn4), .OVW_ERR(ovw4), .ADDR_ERR(ae4)
    );

    rk_stage_bank #(.WIDTH(32), .SLOTS(3), .ADDR_W(2)) u_dut3 (
        .CLK(CLK), .CLR(CLR), .SCLR(SCLR), .LD(LD), .WR_ADDR(WA), .DATA_IN(DIN),
        .RD_ADDR_A(RA), .RD_ADDR_B(RB), .DATA_A(da3), .DATA_B(db3), .VALID(v3),
        .ALL_VALID(av3), .DONE(dn3), .OVW_ERR(ovw3), .ADDR_ERR(ae3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit all_set(input logic [3:0] v, input int ns);
        for (int i = 0; i < ns; i++) begin
            if (!v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++) m_slot[d][s] = '0;
            m_valid[d] = '0;
            m_da[d]    = '0;
            m_db[d]    = '0;
            m_done[d]  = 1'b0;
            m_ovw[d]   = 1'b0;
            m_aerr[d]  = 1'b0;
        end
    endtask

    // Applies one clock edge to the model using the inputs held across that edge.
    task automatic model_update();
        int ns;
        bit was;
        if (CLR) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            ns = (d == 0) ? 4 : 3;
            if (SCLR) begin
                for (int s = 0; s < 4; s++) m_slot[d][s] = '0;
                m_valid[d] = '0;
                m_da[d]    = '0;
                m_db[d]    = '0;
                m_done[d]  = 1'b0;
                m_ovw[d]   = 1'b0;
                m_aerr[d]  = 1'b0;
            end else begin
                was = all_set(m_valid[d], ns);
                m_da[d] = (int'(RA) < ns) ? ((LD && WA == RA) ? DIN : m_slot[d][RA]) : 32'h0;
                m_db[d] = (int'(RB) < ns) ? ((LD && WA == RB) ? DIN : m_slot[d][RB]) : 32'h0;
                if ((LD && int'(WA) >= ns) || int'(RA) >= ns || int'(RB) >= ns) m_aerr[d] = 1'b1;
                if (LD && int'(WA) < ns) begin
                    if (m_valid[d][WA]) m_ovw[d] = 1'b1;
                    m_slot[d][WA]  = DIN;
                    m_valid[d][WA] = 1'b1;
                end
                m_done[d] = all_set(m_valid[d], ns) && !was;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("da4",  da4,  m_da[0]);
            chk("db4",  db4,  m_db[0]);
            chk("v4",   {28'h0, v4}, {28'h0, m_valid[0]});
            chk("av4",  {31'h0, av4}, {31'h0, all_set(m_valid[0], 4)});
            chk("dn4",  {31'h0, dn4}, {31'h0, m_done[0]});
            chk("ovw4", {31'h0, ovw4}, {31'h0, m_ovw[0]});
            chk("ae4",  {31'h0, ae4}, {31'h0, m_aerr[0]});
            chk("da3",  da3,  m_da[1]);
            chk("db3",  db3,  m_db[1]);
            chk("v3",   {29'h0, v3}, {29'h0, m_valid[1][2:0]});
            chk("av3",  {31'h0, av3}, {31'h0, all_set(m_valid[1], 3)});
            chk("dn3",  {31'h0, dn3}, {31'h0, m_done[1]});
            chk("ovw3", {31'h0, ovw3}, {31'h0, m_ovw[1]});
            chk("ae3",  {31'h0, ae3}, {31'h0, m_aerr[1]});
        end
    end

    task automatic cyc(input logic ld, input logic [1:0] wa, input logic [31:0] din,
                       input logic [1:0] ra, input logic [1:0] rb, input logic sclr);
        LD   = ld;
        WA   = wa;
        DIN  = din;
        RA   = ra;
        RB   = rb;
        SCLR = sclr;
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_da4"}, da4, 32'h0);
        chk({nm, "_db4"}, db4, 32'h0);
        chk({nm, "_v4"},  {28'h0, v4}, 32'h0);
        chk({nm, "_dn4"}, {31'h0, dn4}, 32'h0);
        chk({nm, "_ovw4"}, {31'h0, ovw4}, 32'h0);
        chk({nm, "_ae4"}, {31'h0, ae4}, 32'h0);
        chk({nm, "_ae3"}, {31'h0, ae3}, 32'h0);
    endtask

    initial begin
        CLR  = 1'b1;
        SCLR = 1'b0;
        LD   = 1'b0;
        WA   = '0;
        DIN  = '0;
        RA   = '0;
        RB   = '0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #2 CLR = 1'b0;
        chk_en = 1;
        chk_all_zero("reset");

        // Fill the bank and watch the valid flags accumulate
        cyc(1, 0, 32'h0001_0000, 0, 0, 0);
        chk("t2_v0", {28'h0, v4}, 32'h1);
        chk("t2_dn0", {31'h0, dn4}, 32'h0);
        cyc(1, 1, 32'h0002_8000, 0, 0, 0);
        chk("t2_v1", {28'h0, v4}, 32'h3);
        cyc(1, 2, 32'hFFFF_0000, 0, 0, 0);
        chk("t2_v2", {28'h0, v4}, 32'h7);
        chk("t2_dn2", {31'h0, dn4}, 32'h0);
        cyc(1, 3, 32'h0000_0001, 0, 0, 0);
        chk("t2_v3", {28'h0, v4}, 32'hF);
        chk("t2_dn3", {31'h0, dn4}, 32'h1);
        chk("t2_av", {31'h0, av4}, 32'h1);
        chk("t6_v3", {29'h0, v3}, 32'h7);
        chk("t6_ae3", {31'h0, ae3}, 32'h1);

        cyc(0, 0, 0, 2, 0, 0);
        chk("t3_da", da4, 32'hFFFF_0000);
        chk("t3_db", db4, 32'h0001_0000);
        chk("t3_dn", {31'h0, dn4}, 32'h0);

        cyc(0, 0, 0, 3, 3, 0);
        chk("t6_da3", da3, 32'h0);
        chk("t6_db3", db3, 32'h0);
        chk("t6_da4", da4, 32'h0000_0001);
        chk("t6_ae4", {31'h0, ae4}, 32'h0);

        cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
        chk("t4_da", da4, 32'hDEAD_BEEF);
        chk("t4_ovw", {31'h0, ovw4}, 32'h1);
        chk("t4_dn", {31'h0, dn4}, 32'h0);

        cyc(1, 0, 32'h1234_5678, 0, 0, 1);
        chk_all_zero("t5");
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_slot0", da4, 32'h0);

        // Asynchronous clear mid-cycle, away from any clock edge
        cyc(1, 0, 32'hAAAA_0001, 0, 0, 0);
        cyc(1, 2, 32'hAAAA_0002, 2, 0, 0);
        cyc(1, 2, 32'hAAAA_0003, 2, 0, 0);
        chk("t1_pre_da", da4, 32'hAAAA_0003);
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        chk_all_zero("t1_clr");
        cyc(1, 1, 32'h5555_5555, 1, 1, 0);
        chk("t1_held", da4, 32'h0);
        #2 CLR = 1'b0;

        for (int n = 0; n < 800; n++) begin
            cyc(($urandom % 3) != 0, 2'($urandom % 4), $urandom, 2'($urandom % 4),
                2'($urandom % 4), ($urandom % 40) == 0);
            if (($urandom % 97) == 0) begin
                #2;
                CLR = 1'b1;
                model_reset();
                #1;
                chk("rnd_clr_v4", {28'h0, v4}, 32'h0);
                CLR = 1'b0;
            end
        end

        @(negedge CLK);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
